if_stage: RTL

//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC register, selects
//   the next PC, drives the combinational instruction memory (im), and captures
//   pc/instr into the IF/ID pipeline register. Handles stall, branch/jump redirect
//   (one delay slot), exception flush and instruction-address faults (AdEL).

---
 rtl/if_stage.sv | 68 ++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch-address fault detection
// and the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] PCBASE   = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096,
  parameter logic [4:0]  EXC_ADEL = 5'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] im_pc,
  input  logic [31:0] im_instr,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc8,
  output logic [31:0] if_id_instr,
  output logic [4:0]  if_id_excode
);

  // 33 bits so a full 4 GiB memory size cannot overflow the limit.
  localparam logic [32:0] ImBytes = 33'(IM_WORDS) << 2;

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_plus8;
  logic [31:0] w_offset;
  logic        w_fault;

  assign im_pc      = r_pc;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_plus8 = r_pc + 32'd8;
  assign w_offset   = r_pc - PCBASE;

  always_comb begin
    w_fault = (r_pc[1:0] != 2'b00) || (r_pc < PCBASE) || ({1'b0, w_offset} >= ImBytes);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= PCBASE;
      if_id_valid  <= 1'b0;
      if_id_pc     <= 32'h0;
      if_id_pc8    <= 32'h0;
      if_id_instr  <= 32'h0;
      if_id_excode <= 5'd0;
    end else if (flush) begin
      r_pc         <= flush_pc;
      if_id_valid  <= 1'b0;
      if_id_pc     <= 32'h0;
      if_id_pc8    <= 32'h0;
      if_id_instr  <= 32'h0;
      if_id_excode <= 5'd0;
    end else if (!stall) begin
      // A taken branch still captures the current fetch: it is the delay slot.
      r_pc         <= br_taken ? br_target : w_pc_plus4;
      if_id_valid  <= 1'b1;
      if_id_pc     <= r_pc;
      if_id_pc8    <= w_pc_plus8;
      if_id_instr  <= w_fault ? 32'h0 : im_instr;
      if_id_excode <= w_fault ? EXC_ADEL : 5'd0;
    end
  end

endmodule
